// File: rtl/alu_yinelemeli.sv
// RV32I/RV32M execute unit: single-cycle ALU ops plus an optional iterative multiply/divide
// engine enabled by defining ALU_M_EXT_EN.
module alu_yinelemeli #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] s1,
  input  logic [DATA_WIDTH-1:0] s2,
  input  logic [6:0]            opcode,
  input  logic [2:0]            f3,
  input  logic [6:0]            f7,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] d3,
  output logic                  illegal,
  output logic                  busy
);

  localparam int unsigned W = DATA_WIDTH;
  localparam logic [6:0] OpReg = 7'b0110011;
  localparam logic [6:0] OpImm = 7'b0010011;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   d3_q, d3_d;
  logic           illegal_q, illegal_d;
  logic           accept, m_start;

  logic [SHAMT_W-1:0] shamt;
  logic               alt, dec_ill, m_class;
  logic [W-1:0]       alu_res;

  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept    = in_valid && in_ready;
  assign m_start   = accept && m_class;
  assign out_valid = (state_q == StDone);
  assign d3        = d3_q;
  assign illegal   = illegal_q;

  // Decode and single-cycle datapath, evaluated on the live inputs at the handshake.
  always_comb begin
    shamt   = s2[SHAMT_W-1:0];
    alt     = 1'b0;
    dec_ill = 1'b0;
    m_class = 1'b0;
    alu_res = '0;
    if (opcode == OpReg) begin
      if (f7 == 7'b0000000) begin
        alt = 1'b0;
      end else if (f7 == 7'b0100000) begin
        alt     = 1'b1;
        dec_ill = (f3 != 3'b000) && (f3 != 3'b101);
      end else if (f7 == 7'b0000001) begin
`ifdef ALU_M_EXT_EN
        m_class = 1'b1;
`else
        dec_ill = 1'b1;
`endif
      end else begin
        dec_ill = 1'b1;
      end
    end else if (opcode == OpImm) begin
      alt = (f3 == 3'b101) && f7[5];
    end else begin
      dec_ill = 1'b1;
    end

    if (!dec_ill && !m_class) begin
      case (f3)
        3'b000: alu_res = alt ? (s1 - s2) : (s1 + s2);
        3'b001: alu_res = s1 << shamt;
        3'b010: alu_res = {{(W-1){1'b0}}, ($signed(s1) < $signed(s2))};
        3'b011: alu_res = {{(W-1){1'b0}}, (s1 < s2)};
        3'b100: alu_res = s1 ^ s2;
        3'b101: begin
          if (alt) alu_res = $unsigned($signed(s1) >>> shamt);
          else     alu_res = s1 >> shamt;
        end
        3'b110: alu_res = s1 | s2;
        3'b111: alu_res = s1 & s2;
        default: alu_res = '0;
      endcase
    end
  end

`ifdef ALU_M_EXT_EN
  // Iterative engine: acc/lo hold {product hi, multiplier} or {remainder, quotient}.
  logic [W-1:0]       acc_q, lo_q, opnd_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [2:0]         op_q;
  logic               neg_q, rneg_q, divzero_q;

  logic               s1_neg, s2_neg, m_last;
  logic [W-1:0]       mag1, mag2, acc_nx, lo_nx, quo, rem, m_res;
  logic [W:0]         sum, shifted, diff;
  logic [2*W-1:0]     prod;

  always_comb begin
    s1_neg = s1[W-1] && ((f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b110));
    s2_neg = s2[W-1] && ((f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110));
    mag1   = s1_neg ? (~s1 + 1'b1) : s1;
    mag2   = s2_neg ? (~s2 + 1'b1) : s2;
  end

  always_comb begin
    sum     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    shifted = {acc_q, lo_q[W-1]};
    diff    = shifted - {1'b0, opnd_q};
    if (op_q[2]) begin
      if (diff[W]) begin
        acc_nx = shifted[W-1:0];
        lo_nx  = {lo_q[W-2:0], 1'b0};
      end else begin
        acc_nx = diff[W-1:0];
        lo_nx  = {lo_q[W-2:0], 1'b1};
      end
    end else begin
      acc_nx = sum[W:1];
      lo_nx  = {sum[0], lo_q[W-1:1]};
    end

    prod = {acc_nx, lo_nx};
    if (neg_q) prod = ~prod + 1'b1;
    // Division by zero forces an all-ones quotient; the remainder naturally equals s1.
    quo = divzero_q ? {W{1'b1}} : (neg_q ? (~lo_nx + 1'b1) : lo_nx);
    rem = rneg_q ? (~acc_nx + 1'b1) : acc_nx;

    case (op_q)
      3'b000:                 m_res = prod[W-1:0];
      3'b001, 3'b010, 3'b011: m_res = prod[2*W-1:W];
      3'b100, 3'b101:         m_res = quo;
      default:                m_res = rem;
    endcase
    m_last = (cnt_q == SHAMT_W'(W - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else if (m_start) begin
      acc_q     <= '0;
      lo_q      <= f3[2] ? mag1 : mag2;
      opnd_q    <= f3[2] ? mag2 : mag1;
      cnt_q     <= '0;
      op_q      <= f3;
      neg_q     <= s1_neg ^ s2_neg;
      rneg_q    <= s1_neg;
      divzero_q <= (s2 == '0);
    end else if (state_q == StCalc) begin
      acc_q <= acc_nx;
      lo_q  <= lo_nx;
      cnt_q <= cnt_q + SHAMT_W'(1);
    end
  end

  assign busy = (state_q == StCalc);
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    d3_d      = d3_q;
    illegal_d = illegal_q;
    case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          if (m_class) begin
            state_d = StCalc;
          end else begin
            state_d   = StDone;
            d3_d      = alu_res;
            illegal_d = dec_ill;
          end
        end else if ((state_q == StDone) && out_ready) begin
          state_d = StIdle;
        end
      end
      StCalc: begin
`ifdef ALU_M_EXT_EN
        if (m_last) begin
          state_d   = StDone;
          d3_d      = m_res;
          illegal_d = 1'b0;
        end
`else
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      d3_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      d3_q      <= d3_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_yinelemeli.sv
// Directed self-checking bench for alu_yinelemeli; expectations adapt to ALU_M_EXT_EN.
module tb_alu_yinelemeli;

`ifdef ALU_M_EXT_EN
  localparam bit MExt = 1'b1;
`else
  localparam bit MExt = 1'b0;
`endif
  localparam logic [6:0] OpReg = 7'b0110011;
  localparam logic [6:0] OpImm = 7'b0010011;
  localparam logic [6:0] F7Mul = 7'b0000001;
  localparam logic [6:0] F7Alt = 7'b0100000;

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready, illegal, busy;
  logic [31:0] s1, s2, d3;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;

  int tests = 0;
  int fails = 0;

  alu_yinelemeli #(.DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .s1       (s1),
    .s2       (s2),
    .opcode   (opcode),
    .f3       (f3),
    .f7       (f7),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .d3       (d3),
    .illegal  (illegal),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present an op and hold it until the handshake edge has passed.
  task automatic send(input logic [6:0] opc, input logic [2:0] fn3, input logic [6:0] fn7,
                      input logic [31:0] a, input logic [31:0] b);
    int n;
    opcode = opc; f3 = fn3; f7 = fn7; s1 = a; s2 = b; in_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 100);
    check_eq("send_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic get(output logic [31:0] res, output logic ill, output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    do begin @(negedge clk); lat++; if (busy) bcnt++; end while (!out_valid && lat < 100);
    res = d3; ill = illegal;
    @(posedge clk); #1;
  endtask

  task automatic run(input string tag, input logic [6:0] opc, input logic [2:0] fn3,
                     input logic [6:0] fn7, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input logic exp_ill, input int exp_lat,
                     input int exp_busy);
    logic [31:0] res;
    logic        ill;
    int          lat, bc;
    send(opc, fn3, fn7, a, b);
    get(res, ill, lat, bc);
    check_eq({tag, " d3"}, res, exp);
    check_eq({tag, " illegal"}, {31'b0, ill}, {31'b0, exp_ill});
    check_eq({tag, " latency"}, lat, exp_lat);
    check_eq({tag, " busy_cycles"}, bc, exp_busy);
  endtask

  task automatic run_m(input string tag, input logic [2:0] fn3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    run(tag, OpReg, fn3, F7Mul, a, b, MExt ? exp : 32'd0, !MExt, MExt ? 33 : 1, MExt ? 32 : 0);
  endtask

  logic [6:0]  st_opc [3] = '{OpReg, OpReg, OpImm};
  logic [2:0]  st_f3  [3] = '{3'b000, 3'b101, 3'b110};
  logic [6:0]  st_f7  [3] = '{F7Alt, F7Alt, 7'b0000000};
  logic [31:0] st_a   [3] = '{32'd5, 32'h8000_0000, 32'h0F0F_0000};
  logic [31:0] st_b   [3] = '{32'd7, 32'd4, 32'h0000_00FF};
  logic [31:0] st_exp [3] = '{32'hFFFF_FFFE, 32'hF800_0000, 32'h0F0F_00FF};

  initial begin
    int bad;
    logic [31:0] res;
    logic        ill;
    int          lat, bc;

    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    opcode = OpReg; f3 = 3'b000; f7 = 7'b0; s1 = 32'd5; s2 = 32'd5;
    @(posedge clk);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || d3 !== 32'd0 || busy !== 1'b0 || illegal !== 1'b0) bad++;
    end
    check_eq("reset_quiet", bad, 0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_eq("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check_eq("reset_no_result", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    check_eq("reset_no_accept", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;

    // Back-to-back stream with out_ready held high.
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        opcode = st_opc[i]; f3 = st_f3[i]; f7 = st_f7[i];
        s1 = st_a[i]; s2 = st_b[i]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 3) check_eq("stream_in_ready", {31'b0, in_ready}, 32'd1);
      if (i > 0) begin
        check_eq("stream_valid", {31'b0, out_valid}, 32'd1);
        check_eq("stream_d3", d3, st_exp[i-1]);
      end
      @(posedge clk); #1;
    end

    run("slt",   OpReg, 3'b010, 7'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1, 0);
    run("sltu",  OpReg, 3'b011, 7'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1, 0);
    run("sll",   OpReg, 3'b001, 7'b0, 32'd1, 32'h3F, 32'h8000_0000, 1'b0, 1, 0);
    run("srli",  OpImm, 3'b101, 7'b0, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1, 0);
    run("srai",  OpImm, 3'b101, F7Alt, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1, 0);
    run("xor",   OpReg, 3'b100, 7'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 1'b0, 1, 0);
    run("addi",  OpImm, 3'b000, F7Alt, 32'd5, 32'd7, 32'd12, 1'b0, 1, 0);
    run("ill_f7alt", OpReg, 3'b001, F7Alt, 32'd3, 32'd4, 32'd0, 1'b1, 1, 0);
    run("ill_opc",   7'b0110111, 3'b000, 7'b0, 32'd3, 32'd4, 32'd0, 1'b1, 1, 0);

    run_m("mulh",   3'b001, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    run_m("mul",    3'b000, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
    run_m("mulhu",  3'b011, 32'hFFFF_FFFF, 32'd2, 32'd1);
    run_m("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    run_m("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_m("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_m("divu_z",  3'b101, 32'd9, 32'd0, 32'hFFFF_FFFF);
    run_m("remu_z",  3'b111, 32'd9, 32'd0, 32'd9);
    run_m("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_m("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_m("div_z",   3'b100, 32'd7, 32'd0, 32'hFFFF_FFFF);
    run_m("rem_z",   3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);

    // Backpressure: result must hold and no new op may be accepted.
    out_ready = 1'b0;
    send(OpReg, 3'b000, 7'b0, 32'd10, 32'd20);
    opcode = OpReg; f3 = 3'b111; f7 = 7'b0; s1 = 32'hF0F0_F0F0; s2 = 32'hFF00_FF00;
    in_valid = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || d3 !== 32'd30 || in_ready !== 1'b0) bad++;
    end
    check_eq("bp_hold", bad, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    get(res, ill, lat, bc);
    check_eq("bp_next_d3", res, 32'hF000_F000);
    check_eq("bp_next_latency", lat, 1);

    // Abort an in-flight divide with reset.
    send(OpReg, 3'b100, F7Mul, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    check_eq("abort_busy", {31'b0, busy}, {31'b0, MExt});
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    check_eq("abort_no_result", bad, 0);
    @(posedge clk); #1;
    run("add_after_abort", OpReg, 3'b000, 7'b0, 32'd1, 32'd2, 32'd3, 1'b0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
